// File: rtl/cmp_search_ctrl_pkg.sv
// Shared definitions for the comparator-driven successive-approximation search controller.
// Optional macro CMP_SEARCH_VERIFY_EN adds the VERIFY state to the state type.
package cmp_search_ctrl_pkg;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_ONE  = 3'b001;
    localparam logic [2:0] SEL_EQ   = 3'b010;
    localparam logic [2:0] SEL_NE   = 3'b011;
    localparam logic [2:0] SEL_GE   = 3'b100;
    localparam logic [2:0] SEL_LE   = 3'b101;
    localparam logic [2:0] SEL_LT   = 3'b110;
    localparam logic [2:0] SEL_GT   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
`ifdef CMP_SEARCH_VERIFY_EN
        ST_VERIFY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary search for an unknown X using an external comparator (probe <= X), one query per cycle.
// Optional macro CMP_SEARCH_VERIFY_EN adds a final equality check that sets err on mismatch.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; SEL/probe parked at constant-0
// ST_SEARCH | one comparator query per cycle, MSB first, N cycles total
// ST_VERIFY | probe=result with SEL=EQ; err captures a mismatch
// ST_DONE   | done pulses for one cycle, then back to IDLE
module cmp_search_ctrl
    import cmp_search_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [2:0]   SEL,
    output logic [N-1:0] probe,
    input  logic         cmp_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         state, state_nxt;
    logic [2:0]     sel_q, sel_nxt;
    logic [N-1:0]   probe_q, probe_nxt;
    logic [N-1:0]   trial, trial_nxt;
    logic [N-1:0]   result_q, result_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic [N-1:0]   bit_i;
    logic [N-1:0]   kept;
`ifdef CMP_SEARCH_VERIFY_EN
    logic           err_q, err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel_q    <= SEL_ZERO;
            probe_q  <= '0;
            trial    <= '0;
            result_q <= '0;
            idx      <= '0;
`ifdef CMP_SEARCH_VERIFY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            sel_q    <= sel_nxt;
            probe_q  <= probe_nxt;
            trial    <= trial_nxt;
            result_q <= result_nxt;
            idx      <= idx_nxt;
`ifdef CMP_SEARCH_VERIFY_EN
            err_q    <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel_q;
        probe_nxt  = probe_q;
        trial_nxt  = trial;
        result_nxt = result_q;
        idx_nxt    = idx;
`ifdef CMP_SEARCH_VERIFY_EN
        err_nxt    = err_q;
`endif
        // bit under test this cycle; kept keeps it only if probe <= X
        bit_i = N'(1) << idx;
        kept  = trial | (cmp_in ? bit_i : '0);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SEARCH;
                    trial_nxt = '0;
                    idx_nxt   = IW'(N - 1);
                    probe_nxt = N'(1) << (N - 1);
                    sel_nxt   = SEL_LE;
`ifdef CMP_SEARCH_VERIFY_EN
                    err_nxt   = 1'b0;
`endif
                end
            end
            ST_SEARCH: begin
                trial_nxt = kept;
                if (idx != '0) begin
                    probe_nxt = kept | (bit_i >> 1);
                    idx_nxt   = idx - IW'(1);
                end else begin
                    result_nxt = kept;
`ifdef CMP_SEARCH_VERIFY_EN
                    state_nxt  = ST_VERIFY;
                    probe_nxt  = kept;
                    sel_nxt    = SEL_EQ;
`else
                    state_nxt  = ST_DONE;
                    probe_nxt  = '0;
                    sel_nxt    = SEL_ZERO;
`endif
                end
            end
`ifdef CMP_SEARCH_VERIFY_EN
            ST_VERIFY: begin
                err_nxt   = ~cmp_in;
                state_nxt = ST_DONE;
                probe_nxt = '0;
                sel_nxt   = SEL_ZERO;
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                probe_nxt = '0;
                sel_nxt   = SEL_ZERO;
            end
        endcase
    end

    assign SEL    = sel_q;
    assign probe  = probe_q;
    assign result = result_q;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
`ifdef CMP_SEARCH_VERIFY_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: behavioural comparator, scoreboard queues for probes and results.
module tb_cmp_search_ctrl;
    import cmp_search_ctrl_pkg::*;

    localparam int N = 8;
`ifdef CMP_SEARCH_VERIFY_EN
    localparam int DONE_CYC = N + 2;
`else
    localparam int DONE_CYC = N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   SEL;
    logic [N-1:0] probe;
    logic         cmp_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         err;

    logic [N-1:0] x_val;
    logic         fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] exp_probe_q[$];
    logic [N-1:0] exp_res_q[$];
    logic         exp_err_q[$];

    cmp_search_ctrl #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .SEL    (SEL),
        .probe  (probe),
        .cmp_in (cmp_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    // external comparator: value1 = probe, value2 = X
    always_comb begin
        cmp_in = 1'b0;
        case (SEL)
            SEL_ZERO: cmp_in = 1'b0;
            SEL_ONE:  cmp_in = 1'b1;
            SEL_EQ:   cmp_in = (probe == x_val);
            SEL_NE:   cmp_in = (probe != x_val);
            SEL_GE:   cmp_in = (probe >= x_val);
            SEL_LE:   cmp_in = (probe <= x_val);
            SEL_LT:   cmp_in = (probe <  x_val);
            SEL_GT:   cmp_in = (probe >  x_val);
            default:  cmp_in = 1'b0;
        endcase
        if (fault && SEL == SEL_LE)
            cmp_in = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"},   32'(busy),   32'd0);
        check_val({tag, "_done"},   32'(done),   32'd0);
        check_val({tag, "_sel"},    32'(SEL),    32'd0);
        check_val({tag, "_probe"},  32'(probe),  32'd0);
        check_val({tag, "_result"}, 32'(result), 32'd0);
        check_val({tag, "_err"},    32'(err),    32'd0);
    endtask

    // repulse_at: cycle (relative to the start cycle) at which start is driven again, 0 = never
    task automatic do_search(input string tag, input logic [N-1:0] x, input int repulse_at,
                             input logic faulty);
        logic [N-1:0] tr;
        logic [N-1:0] p;
        int n_done;
        int n_probe;
        tr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            p = tr | (N'(1) << i);
            exp_probe_q.push_back(p);
            if (faulty || p <= x)
                tr = p;
        end
        exp_res_q.push_back(tr);
`ifdef CMP_SEARCH_VERIFY_EN
        exp_err_q.push_back(tr != x);
`else
        exp_err_q.push_back(1'b0);
`endif
        x_val = x;
        fault = faulty;
        n_done = 0;
        n_probe = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= DONE_CYC + 2; c++) begin
            check_val({tag, "_busy"}, 32'(busy), 32'(c <= DONE_CYC));
            if (SEL == SEL_LE) begin
                n_probe++;
                if (exp_probe_q.size() > 0)
                    check_val({tag, "_probe"}, 32'(probe), 32'(exp_probe_q.pop_front()));
            end
            if (done) begin
                n_done++;
                check_val({tag, "_done_cyc"}, 32'(c), 32'(DONE_CYC));
                check_val({tag, "_done_sel"}, 32'(SEL), 32'(SEL_ZERO));
                check_val({tag, "_done_probe"}, 32'(probe), 32'd0);
                if (exp_res_q.size() > 0) begin
                    check_val({tag, "_result"}, 32'(result), 32'(exp_res_q.pop_front()));
                    check_val({tag, "_err"}, 32'(err), 32'(exp_err_q.pop_front()));
                end
            end
            start = (c == repulse_at);
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, "_n_done"}, 32'(n_done), 32'd1);
        check_val({tag, "_n_probe"}, 32'(n_probe), 32'(N));
        exp_probe_q.delete();
        exp_res_q.delete();
        exp_err_q.delete();
        fault = 1'b0;
    endtask

    task automatic reset_mid_search(input logic [N-1:0] x);
        int n_done;
        n_done = 0;
        x_val = x;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (done) n_done++;
            if (c == 4) rst = 1'b1;
            @(negedge clk);
        end
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        for (int c = 0; c < DONE_CYC + 3; c++) begin
            if (done || busy) n_done++;
            @(negedge clk);
        end
        check_val("rst_mid_no_done", 32'(n_done), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_val = '0;
        fault = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        do_search("x00", 8'h00, 0, 1'b0);
        do_search("xff", 8'hFF, 0, 1'b0);
        do_search("xa5", 8'hA5, 0, 1'b0);
        do_search("x3c_repulse", 8'h3C, 3, 1'b0);
        do_search("x5a_start_on_done", 8'h5A, DONE_CYC, 1'b0);
        reset_mid_search(8'h3C);
        do_search("after_rst", 8'h69, 0, 1'b0);
`ifdef CMP_SEARCH_VERIFY_EN
        do_search("verify_fault", 8'h10, 0, 1'b1);
        do_search("verify_ok", 8'h77, 0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
